// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial sequence detector.
// Matches a right-aligned pattern of 1..MAX_LEN bits on a qualified serial
// stream, with overlap/non-overlap selection, a registered one-cycle match
// pulse, an armed flag, a cfg_err pulse for rejected loads and a saturating
// match counter.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit don't-care mask input
// (cfg_mask), latched together with the rest of the configuration.
module seq_det_prog #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0110,
  parameter int unsigned        DEF_LEN     = 5,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int unsigned       LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               match,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] cmp_mask;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      fill_inc;
  logic               ovl_q, ovl_d;
  logic               match_q, armed_q, err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_ok, cfg_bad, hit;

`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] cmask_q, cmask_d;
`endif

  // Thermometer mask selecting the low len_q history bits.
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
  end

`ifdef SEQ_DET_MASK_EN
  assign cmp_mask = len_mask & cmask_q;
`else
  assign cmp_mask = len_mask;
`endif

  // Next-state: config load, history shift, hit detection and counter.
  always_comb begin
    cfg_ok   = cfg_load && (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    cfg_bad  = cfg_load && !cfg_ok;
    hist_sh  = {hist_q[MAX_LEN-2:0], in};
    fill_inc = (fill_q >= MAX_LEN_L) ? fill_q : fill_q + LW'(1);
    // A valid load discards the incoming bit, so it can never complete a hit.
    hit      = !cfg_ok && in_valid && (fill_inc >= len_q) &&
               (((hist_sh ^ pat_q) & cmp_mask) == '0);

    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
`ifdef SEQ_DET_MASK_EN
    cmask_d = cmask_q;
`endif

    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
`ifdef SEQ_DET_MASK_EN
      cmask_d = cfg_mask;
`endif
    end else if (in_valid) begin
      hist_d = hist_sh;
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
    end

    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQ_DET_MASK_EN
      cmask_q <= '1;
`endif
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit;
      armed_q <= (fill_d >= len_d);
      err_q   <= cfg_bad;
      cnt_q   <= cnt_d;
`ifdef SEQ_DET_MASK_EN
      cmask_q <= cmask_d;
`endif
    end
  end

  assign match       = match_q;
  assign armed       = armed_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed scenarios plus randomized traffic for
// seq_det_prog, checked cycle by cycle against a queue-based reference model.
// A second instance with a 2-bit counter exercises saturation on the same
// stimulus.
module tb_seq_det_prog;

  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
`ifdef SEQ_DET_MASK_EN
  logic [ML-1:0] cfg_mask;
`endif
  logic          match, armed, cfg_err;
  logic [15:0]   match_count;
  logic          match_s, armed_s, cfg_err_s;
  logic [1:0]    match_count_s;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cnt_clr(cnt_clr), .match(match), .armed(armed), .cfg_err(cfg_err),
    .match_count(match_count)
  );

  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cnt_clr(cnt_clr), .match(match_s), .armed(armed_s), .cfg_err(cfg_err_s),
    .match_count(match_count_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bits since the last clear, newest at the back.
  bit        hq[$];
  int        m_cnt;
  int        m_len;
  bit        m_ovl;
  bit [31:0] m_pat;
  bit [31:0] m_mask;
  int        c16, c2;
  bit        e_match, e_armed, e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_cnt = 0; m_len = 5; m_ovl = 1'b1;
    m_pat = 32'b10110; m_mask = '1;
    c16 = 0; c2 = 0;
    e_match = 0; e_armed = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit ld,
                            input bit [7:0] p, input int l, input bit o,
                            input bit clr, input bit [7:0] mk);
    bit ok, h;
    ok    = ld && (l >= 1) && (l <= ML);
    e_err = ld && !ok;
    h     = 1'b0;
    if (ok) begin
      m_pat = 32'(p); m_len = l; m_ovl = o;
`ifdef SEQ_DET_MASK_EN
      m_mask = 32'(mk);
`else
      m_mask = '1;
      if (mk == 8'h00) m_mask = '1;
`endif
      hq.delete();
      m_cnt = 0;
    end else if (v) begin
      hq.push_back(b);
      if (hq.size() > 40) void'(hq.pop_front());
      m_cnt++;
      if (m_cnt >= m_len) begin
        h = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_mask[k] && (hq[hq.size()-1-k] != m_pat[k])) h = 1'b0;
      end
      if (h && !m_ovl) m_cnt = 0;
    end
    e_match = h;
    e_armed = (m_cnt >= m_len);
    if (clr) begin
      c16 = h ? 1 : 0;
      c2  = h ? 1 : 0;
    end else if (h) begin
      if (c16 < 65535) c16++;
      if (c2 < 3) c2++;
    end
  endtask

  // One clock cycle: drive, advance model, check after the edge.
  task automatic step(input bit v, input bit b, input bit ld = 0,
                      input bit [7:0] p = 0, input int l = 0, input bit o = 0,
                      input bit clr = 0, input bit [7:0] mk = 8'hFF);
    in_valid = v; in_bit = b; cfg_load = ld; cfg_pattern = p;
    cfg_len = LW'(l); cfg_overlap = o; cnt_clr = clr;
`ifdef SEQ_DET_MASK_EN
    cfg_mask = mk;
`endif
    model_step(v, b, ld, p, l, o, clr, mk);
    @(posedge clk);
    #1;
    chk("match", 32'(match), 32'(e_match));
    chk("armed", 32'(armed), 32'(e_armed));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
    chk("match_count", 32'(match_count), 32'(c16));
    chk("match_count_sat2", 32'(match_count_s), 32'(c2));
    in_valid = 0; cfg_load = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_count_sat2", 32'(match_count_s), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic stream(input bit [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i]);
  endtask

  initial begin
    in_valid = 0; in_bit = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;
`ifdef SEQ_DET_MASK_EN
    cfg_mask = '1;
`endif
    rst = 1'b1;
    #2;
    do_reset();

    // Default 10110 overlapping: hits after bit 5 and bit 8.
    stream(32'b10110110, 8);
    chk("default_two_hits", 32'(match_count), 32'd2);

    // Non-overlap: one hit, armed re-rises after bit 10.
    step(0, 0, 1, 8'b10110, 5, 0);
    stream(32'b1011011010, 10);

    // Default config back, bits separated by idle gaps.
    step(0, 0, 1, 8'b10110, 5, 1);
    for (int i = 4; i >= 0; i--) begin
      bit [4:0] pv;
      pv = 5'b10110;
      step(1, pv[i]);
      if (i != 0) begin
        step(0, 1); step(0, 1); step(0, 1);
      end
    end

    // Rejected loads leave the configuration intact.
    step(1, 1, 1, 8'b11, 0, 0);
    step(1, 0, 1, 8'b11, 9, 0);
    stream(32'b110110, 6);

    // Pattern 11 overlapping on a run of ones, then clear with a hit.
    step(0, 0, 1, 8'b11, 2, 1);
    stream(32'b11111, 5);
    chk("ones_four_hits_delta", 32'(match_count), 32'(c16));
    step(1, 1, 0, 0, 0, 0, 1);
    chk("clr_with_hit", 32'(match_count), 32'd1);

    // Single-bit pattern for saturation of the 2-bit counter.
    step(0, 0, 1, 8'b1, 1, 1);
    stream(32'b111111, 6);
    chk("sat2_stuck", 32'(match_count_s), 32'd3);

    // Reset mid-pattern: the trailing 0 must not complete a match.
    do_reset();
    stream(32'b1011, 4);
    do_reset();
    step(1, 0);
    step(1, 0);

`ifdef SEQ_DET_MASK_EN
    step(0, 0, 1, 8'b10110, 5, 1, 0, 8'b11011);
    stream(32'b10010, 5);
    step(0, 0, 1, 8'b10110, 5, 1, 0, 8'b11011);
    stream(32'b10110, 5);
`endif

    // Randomized traffic with occasional reconfiguration and clears.
    for (int n = 0; n < 3000; n++) begin
      bit ld, clr;
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      if (n % 700 == 699) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom), ld, 8'($urandom),
           int'($urandom_range(0, 9)), 1'($urandom), clr, 8'($urandom) | 8'h81);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
